// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, stall, flush and stall counter.
// Define WB_FORWARD_EN to bypass same-edge writeback data into captured and held operands.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              flush,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              regWrite;
  } exReg_t;

  exReg_t            exQ, exD;
  logic              validQ, validD;
  logic [CNT_W-1:0]  stallQ;
  logic              load, hold;
  logic [DATA_W-1:0] capA, capB;

  assign id_ready = !validQ || ex_ready;
  assign load     = id_valid && id_ready && !flush;
  assign hold     = validQ && !ex_ready;

`ifdef WB_FORWARD_EN
  logic wbHit;
  assign wbHit = wb_regwrite && (wb_reg != '0);
`else
  logic unusedWb;
  assign unusedWb = &{1'b0, wb_regwrite, wb_reg, wb_data, exQ.rs, exQ.rt};
`endif

  // r0 reads as zero; a matching writeback overrides the stale regfile read
  always_comb begin
    capA = (id_rs == '0) ? '0 : id_rdata1;
    capB = (id_rt == '0) ? '0 : id_rdata2;
`ifdef WB_FORWARD_EN
    if (wbHit && wb_reg == id_rs) capA = wb_data;
    if (wbHit && wb_reg == id_rt) capB = wb_data;
`endif
  end

  always_comb begin
    exD = exQ;
    if (load) begin
      exD.opA      = capA;
      exD.opB      = capB;
      exD.imm      = id_imm;
      exD.rd       = id_rd;
      exD.rs       = id_rs;
      exD.rt       = id_rt;
      exD.regWrite = id_regwrite;
    end else if (hold && !flush) begin
`ifdef WB_FORWARD_EN
      if (wbHit && wb_reg == exQ.rs) exD.opA = wb_data;
      if (wbHit && wb_reg == exQ.rt) exD.opB = wb_data;
`endif
    end

    if (flush)                  validD = 1'b0;
    else if (load)              validD = 1'b1;
    else if (validQ && ex_ready) validD = 1'b0;
    else                        validD = validQ;

    if (!validD) exD.regWrite = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exQ    <= '0;
      validQ <= 1'b0;
      stallQ <= '0;
    end else begin
      exQ    <= exD;
      validQ <= validD;
      if (hold && stallQ != '1) stallQ <= stallQ + 1'b1;
    end
  end

  assign ex_valid    = validQ;
  assign ex_op_a     = exQ.opA;
  assign ex_op_b     = exQ.opB;
  assign ex_imm      = exQ.imm;
  assign ex_rd       = exQ.rd;
  assign ex_regwrite = exQ.regWrite;
  assign stall_cnt   = stallQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a rule-level model.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n, id_valid, id_regwrite, flush, wb_regwrite, ex_ready;
  logic [AW-1:0] id_rs, id_rt, id_rd, wb_reg;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm, wb_data;
  logic          id_ready, ex_valid, ex_regwrite;
  logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
  logic [AW-1:0] ex_rd;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  // model state
  logic          mValid, mRw;
  logic [DW-1:0] mA, mB, mImm;
  logic [AW-1:0] mRd, mRs, mRt;
  int            mCnt;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_regwrite(id_regwrite), .flush(flush), .wb_regwrite(wb_regwrite),
    .wb_reg(wb_reg), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic logic wbMatch(input logic [AW-1:0] idx);
`ifdef WB_FORWARD_EN
    return wb_regwrite && wb_reg != 0 && wb_reg == idx;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] readOp(input logic [AW-1:0] idx, input logic [DW-1:0] rf);
    if (idx == 0) return 0;
    if (wbMatch(idx)) return wb_data;
    return rf;
  endfunction

  task automatic modelStep();
    logic readyNow, stalled;
    if (!rst_n) begin
      mValid = 0; mRw = 0; mA = 0; mB = 0; mImm = 0; mRd = 0; mRs = 0; mRt = 0; mCnt = 0;
    end else begin
      readyNow = !mValid || ex_ready;
      stalled  = mValid && !ex_ready;
      if (stalled && mCnt < (1 << CW) - 1) mCnt++;
      if (flush) begin
        mValid = 0; mRw = 0;
      end else if (id_valid && readyNow) begin
        mA = readOp(id_rs, id_rdata1); mB = readOp(id_rt, id_rdata2);
        mImm = id_imm; mRd = id_rd; mRs = id_rs; mRt = id_rt; mRw = id_regwrite; mValid = 1;
      end else if (stalled) begin
        if (wbMatch(mRs)) mA = wb_data;
        if (wbMatch(mRt)) mB = wb_data;
      end else if (mValid) begin
        mValid = 0; mRw = 0;
      end
    end
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; id_valid = 0; id_regwrite = 0; flush = 0; wb_regwrite = 0; ex_ready = 1;
    id_rs = 0; id_rt = 0; id_rd = 0; wb_reg = 0;
    id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; wb_data = 0;
  endtask

  task automatic doReset();
    idle();
    rst_n = 0;
    cycle(); cycle();
    rst_n = 1;
  endtask

  task automatic setInstr(input logic [AW-1:0] rs, rt, rd, input logic [DW-1:0] d1, d2, imm);
    id_valid = 1; id_regwrite = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; id_valid = 1; id_regwrite = 1; id_rs = 1; id_rdata1 = 32'hFFFF_FFFF;
    cycle(); cycle();
    vectors++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    vectors++; if (ex_op_a !== 0 || ex_op_b !== 0) begin errors++; $display("FAIL reset_ops got %h/%h want 0", ex_op_a, ex_op_b); end
    vectors++; if (ex_imm !== 0 || ex_rd !== 0) begin errors++; $display("FAIL reset_imm_rd got %h/%0d want 0", ex_imm, ex_rd); end
    vectors++; if (ex_regwrite !== 0 || stall_cnt !== 0) begin errors++; $display("FAIL reset_rw_cnt got %0b/%0d want 0", ex_regwrite, stall_cnt); end
    vectors++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", id_ready); end
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    doReset();
    setInstr(1, 2, 3, 32'h1234_5678, 32'h8765_4321, 32'h0000_0010);
    cycle();
    vectors++; if (ex_valid !== 1'b1 || ex_rd !== 3) begin errors++; $display("FAIL b2b_first valid=%0b rd=%0d want 1/3", ex_valid, ex_rd); end
    vectors++; if (ex_op_a !== 32'h1234_5678 || ex_op_b !== 32'h8765_4321) begin errors++; $display("FAIL b2b_ops got %h/%h want 12345678/87654321", ex_op_a, ex_op_b); end
    vectors++; if (ex_imm !== 32'h10 || ex_regwrite !== 1'b1) begin errors++; $display("FAIL b2b_imm_rw got %h/%0b want 10/1", ex_imm, ex_regwrite); end
    setInstr(4, 5, 7, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0000_0020);
    cycle();
    vectors++; if (ex_valid !== 1'b1 || ex_rd !== 7 || ex_op_a !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_second valid=%0b rd=%0d a=%h want 1/7/a5a50001", ex_valid, ex_rd, ex_op_a); end
    idle(); cycle();
    vectors++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin errors++; $display("FAIL drain valid=%0b rw=%0b want 0/0", ex_valid, ex_regwrite); end
  endtask

  task automatic test_stall();
    doReset();
    setInstr(1, 2, 4, 32'h1111_1111, 32'h0, 32'h0);
    cycle();
    setInstr(1, 2, 5, 32'h2222_2222, 32'h0, 32'h0);
    ex_ready = 0;
    #1;
    vectors++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b want 0", id_ready); end
    cycle(); cycle(); cycle();
    vectors++; if (ex_valid !== 1'b1 || ex_rd !== 4 || ex_op_a !== 32'h1111_1111) begin errors++; $display("FAIL stall_frozen valid=%0b rd=%0d a=%h want 1/4/11111111", ex_valid, ex_rd, ex_op_a); end
    vectors++; if (stall_cnt !== 3) begin errors++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
    ex_ready = 1;
    #1;
    vectors++; if (id_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %0b want 1", id_ready); end
    cycle();
    vectors++; if (ex_rd !== 5 || ex_op_a !== 32'h2222_2222 || ex_valid !== 1'b1) begin errors++; $display("FAIL stall_next rd=%0d a=%h want 5/22222222", ex_rd, ex_op_a); end
    vectors++; if (stall_cnt !== 3) begin errors++; $display("FAIL stall_cnt_keep got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush();
    doReset();
    setInstr(1, 2, 6, 32'h1, 32'h2, 32'h3);
    cycle();
    flush = 1;
    #1;
    vectors++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", id_ready); end
    cycle();
    vectors++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin errors++; $display("FAIL flush_load valid=%0b rw=%0b want 0/0", ex_valid, ex_regwrite); end
    flush = 0; cycle();
    ex_ready = 0; flush = 1; cycle();
    vectors++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin errors++; $display("FAIL flush_hold valid=%0b rw=%0b want 0/0", ex_valid, ex_regwrite); end
    flush = 0; ex_ready = 1;
  endtask

  task automatic test_r0();
    doReset();
    setInstr(0, 0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0);
    wb_regwrite = 1; wb_reg = 0; wb_data = 32'h7777_7777;
    cycle();
    vectors++; if (ex_op_a !== 0 || ex_op_b !== 0) begin errors++; $display("FAIL r0 got %h/%h want 0/0", ex_op_a, ex_op_b); end
  endtask

  task automatic test_forward();
    logic [DW-1:0] expA, expB;
`ifdef WB_FORWARD_EN
    expA = 32'h1234_ABCD; expB = 32'h5678_CDEF;
`else
    expA = 32'h2; expB = 32'h33;
`endif
    doReset();
    setInstr(2, 3, 8, 32'h2, 32'h33, 32'h0);
    wb_regwrite = 1; wb_reg = 2; wb_data = 32'h1234_ABCD;
    cycle();
    vectors++; if (ex_op_a !== expA || ex_op_b !== 32'h33) begin errors++; $display("FAIL fwd_capture got %h/%h want %h/33", ex_op_a, ex_op_b, expA); end
    id_valid = 0; ex_ready = 0; wb_reg = 3; wb_data = 32'h5678_CDEF;
    cycle();
    vectors++; if (ex_op_b !== expB || ex_op_a !== expA) begin errors++; $display("FAIL fwd_snoop got %h/%h want %h/%h", ex_op_a, ex_op_b, expA, expB); end
    idle();
  endtask

  task automatic test_saturate();
    doReset();
    setInstr(1, 1, 1, 32'h9, 32'h9, 32'h9);
    cycle();
    ex_ready = 0; id_valid = 0;
    for (int i = 0; i < 70; i++) cycle();
    vectors++; if (stall_cnt !== {CW{1'b1}}) begin errors++; $display("FAIL saturate got %0d want %0d", stall_cnt, (1 << CW) - 1); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      id_valid    = $urandom_range(0, 3) != 0;
      ex_ready    = $urandom_range(0, 2) != 0;
      flush       = $urandom_range(0, 9) == 0;
      id_regwrite = $urandom_range(0, 1);
      id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3)); id_rd = AW'($urandom);
      id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
      wb_regwrite = $urandom_range(0, 1); wb_reg = AW'($urandom_range(0, 3)); wb_data = $urandom;
      #1;
      vectors++; if (id_ready !== (!mValid || ex_ready)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", i, id_ready, !mValid || ex_ready); end
      cycle();
      vectors++; if (ex_valid !== mValid || ex_regwrite !== mRw) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %0b/%0b want %0b/%0b", i, ex_valid, ex_regwrite, mValid, mRw); end
      vectors++; if (stall_cnt !== CW'(mCnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, stall_cnt, mCnt); end
      if (mValid) begin
        vectors++; if (ex_op_a !== mA || ex_op_b !== mB || ex_imm !== mImm || ex_rd !== mRd) begin errors++; $display("FAIL rnd_data cyc %0d got %h/%h/%h/%0d want %h/%h/%h/%0d", i, ex_op_a, ex_op_b, ex_imm, ex_rd, mA, mB, mImm, mRd); end
      end
    end
  endtask

  initial begin
    idle();
    mValid = 0; mRw = 0; mA = 0; mB = 0; mImm = 0; mRd = 0; mRs = 0; mRt = 0; mCnt = 0;
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_r0();
    test_forward();
    test_saturate();
    doReset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
